// File: rtl/sp_cmd_ctrl.sv
// ============================================================================
// sp_cmd_ctrl - JTAG source/probe command bridge onto a req/ack register bus
// Revision: 1.0
// ============================================================================
`default_nettype none

module sp_cmd_ctrl #(
    parameter  int ADDR_WIDTH = 8,
    parameter  int DATA_WIDTH = 32,
    parameter  int TIMEOUT    = 255,
    localparam int SRC_W      = 2 + ADDR_WIDTH + DATA_WIDTH,
    localparam int PRB_W      = 3 + DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SRC_W-1:0]      source,
    output logic [PRB_W-1:0]      probe,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_TMO     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  r_next;
    logic [SRC_W-1:0]        r_s1;
    logic [SRC_W-1:0]        r_s2;
    logic [SRC_W-1:0]        r_s3;
    logic                    r_last_tog;
    logic                    r_tog;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [CNT_W-1:0]        r_cnt;
    logic [1:0]              r_status;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [PRB_W-1:0]        r_probe;

    logic                    w_detect;
    logic                    w_timeout;

    // A command is taken only once the synchronised word has been stable for a cycle
    assign w_detect  = (r_s2 == r_s3) && (r_s2[SRC_W-1] != r_last_tog);
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == C_TMO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            ST_IDLE: if (w_detect) r_next = ST_REQ;
            ST_REQ:  if (bus_ack || w_timeout) r_next = ST_DONE;
            ST_DONE: r_next = ST_IDLE;
            default: r_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_s3       <= '0;
            r_last_tog <= 1'b0;
            r_tog      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_status   <= 2'b00;
            r_data     <= '0;
            r_probe    <= '0;
        end else begin
            r_s1 <= source;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            case (r_state)
                ST_IDLE: begin
                    if (w_detect) begin
                        r_tog   <= r_s2[SRC_W-1];
                        r_we    <= r_s2[SRC_W-2];
                        r_addr  <= r_s2[DATA_WIDTH +: ADDR_WIDTH];
                        r_wdata <= r_s2[DATA_WIDTH-1:0];
                        r_cnt   <= '0;
                    end
                end
                ST_REQ: begin
                    // Ack has priority over a coincident timeout
                    if (bus_ack) begin
                        r_status <= 2'b00;
                        r_data   <= r_we ? r_wdata : bus_rdata;
                    end else if (w_timeout) begin
                        r_status <= 2'b01;
                        r_data   <= '0;
                    end else if (r_cnt != C_CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_probe    <= {r_tog, r_status, r_data};
                    r_last_tog <= r_tog;
                end
                default: ;
            endcase
        end
    end

    assign bus_req   = (r_state == ST_REQ);
    assign bus_we    = r_we;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign probe     = r_probe;

endmodule

`default_nettype wire

// File: tb/tb_sp_cmd_ctrl.sv
// ============================================================================
// tb_sp_cmd_ctrl - directed self-checking bench for sp_cmd_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sp_cmd_ctrl;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int SRC_W = 2 + AW + DW;
    localparam int PRB_W = 3 + DW;

    logic              clk;
    logic              rst;
    logic [SRC_W-1:0]  source;
    logic [PRB_W-1:0]  probe;
    logic              bus_req;
    logic              bus_we;
    logic [AW-1:0]     bus_addr;
    logic [DW-1:0]     bus_wdata;
    logic              bus_ack;
    logic [DW-1:0]     bus_rdata;

    int n_checks = 0;
    int n_errors = 0;

    sp_cmd_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (8)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .source    (source),
        .probe     (probe),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns number of negedges until bus_req is seen high (bounded)
    task automatic wait_req(input string tag, output int n);
        n = 0;
        while (!bus_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus_req) chk({tag, "_req_timeout"}, 64'(bus_req), 64'd1);
    endtask

    // Pulses bus_ack d cycles after bus_req was first seen, then waits for DONE
    task automatic ack_after(input int d, input logic [DW-1:0] data);
        repeat (d - 1) @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = data;
        @(negedge clk);
        bus_ack   = 1'b0;
        bus_rdata = '0;
        @(negedge clk);
    endtask

    function automatic logic [SRC_W-1:0] mk_src(input logic tog, input logic we,
                                                input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {tog, we, a, d};
    endfunction

    initial begin
        int lat;
        int hi;
        int seen;
        rst       = 1'b1;
        source    = '0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        repeat (3) @(negedge clk);

        chk("rst_probe",   64'(probe),     64'd0);
        chk("rst_req",     64'(bus_req),   64'd0);
        chk("rst_we",      64'(bus_we),    64'd0);
        chk("rst_addr",    64'(bus_addr),  64'd0);
        chk("rst_wdata",   64'(bus_wdata), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Write command
        source = mk_src(1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
        wait_req("wr", lat);
        chk("wr_latency", 64'(lat),       64'd4);
        chk("wr_we",      64'(bus_we),    64'd1);
        chk("wr_addr",    64'(bus_addr),  64'h10);
        chk("wr_wdata",   64'(bus_wdata), 64'hDEADBEEF);
        repeat (1) @(negedge clk);
        bus_ack = 1'b1;
        bus_rdata = 32'h55555555;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("wr_req_drop",   64'(bus_req), 64'd0);
        chk("wr_probe_hold", 64'(probe),   64'd0);
        @(negedge clk);
        chk("wr_probe", 64'(probe), 64'({1'b1, 2'b00, 32'hDEADBEEF}));

        // Read command
        source = mk_src(1'b0, 1'b0, 8'h04, 32'h0);
        wait_req("rd", lat);
        chk("rd_latency", 64'(lat),      64'd4);
        chk("rd_we",      64'(bus_we),   64'd0);
        chk("rd_addr",    64'(bus_addr), 64'h04);
        @(negedge clk);
        chk("rd_we_mid",  64'(bus_we),   64'd0);
        ack_after(2, 32'h12345678);
        chk("rd_probe", 64'(probe), 64'({1'b0, 2'b00, 32'h12345678}));

        // Timeout: no ack
        source = mk_src(1'b1, 1'b0, 8'h20, 32'h0);
        wait_req("to", lat);
        hi = 0;
        while (bus_req && hi < 50) begin
            hi++;
            @(negedge clk);
        end
        chk("to_req_cycles", 64'(hi), 64'd9);
        @(negedge clk);
        chk("to_probe", 64'(probe), 64'({1'b1, 2'b01, 32'h0}));

        // Source flipped during REQ
        source = mk_src(1'b0, 1'b0, 8'h30, 32'h0);
        wait_req("fl1", lat);
        source = mk_src(1'b1, 1'b0, 8'h40, 32'h0);
        @(negedge clk);
        chk("fl1_addr_held", 64'(bus_addr), 64'h30);
        ack_after(1, 32'hAAAA5555);
        chk("fl1_probe", 64'(probe), 64'({1'b0, 2'b00, 32'hAAAA5555}));
        wait_req("fl2", lat);
        chk("fl2_latency", 64'(lat),      64'd1);
        chk("fl2_addr",    64'(bus_addr), 64'h40);
        ack_after(1, 32'h0BADF00D);
        chk("fl2_probe", 64'(probe), 64'({1'b1, 2'b00, 32'h0BADF00D}));

        // Same toggle, new data, stray ack: nothing happens
        source = mk_src(1'b1, 1'b1, 8'h40, 32'h11111111);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus_ack = 1'b1;
                bus_rdata = 32'h77777777;
            end else begin
                bus_ack = 1'b0;
            end
            @(negedge clk);
            if (bus_req) seen++;
        end
        bus_ack = 1'b0;
        chk("noop_req",   64'(seen),  64'd0);
        chk("noop_probe", 64'(probe), 64'({1'b1, 2'b00, 32'h0BADF00D}));

        // Asynchronous reset mid-REQ
        source = mk_src(1'b0, 1'b1, 8'h50, 32'h5);
        wait_req("ar", lat);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("ar_req_drop", 64'(bus_req), 64'd0);
        chk("ar_probe",    64'(probe),   64'd0);
        @(negedge clk);
        source = mk_src(1'b1, 1'b1, 8'h60, 32'hCAFEF00D);
        @(negedge clk);
        rst = 1'b0;
        wait_req("ar2", lat);
        chk("ar2_latency", 64'(lat),      64'd4);
        chk("ar2_addr",    64'(bus_addr), 64'h60);
        ack_after(1, 32'h0);
        chk("ar2_probe", 64'(probe), 64'({1'b1, 2'b00, 32'hCAFEF00D}));
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_req) seen++;
        end
        chk("ar2_single", 64'(seen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/sp_cmd_ctrl.md
SP_CMD_CTRL -- requirements
Module: sp_cmd_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, width of the register-bus address field.
REQ-002 Parameter DATA_WIDTH, default 32, width of the register-bus data fields.
REQ-003 Parameter TIMEOUT, default 255, maximum wait for bus_ack, in cycles; 0 disables the timeout.
REQ-004 Derived widths: SRC_W = 2+ADDR_WIDTH+DATA_WIDTH; PRB_W = 3+DATA_WIDTH.
REQ-005 clk  in  1  single block clock; also clocks the attached source/probe instance (its source_clk).
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 source  in  SRC_W  JTAG-written command word: [SRC_W-1] cmd toggle, [SRC_W-2] we, next ADDR_WIDTH bits addr, low DATA_WIDTH bits wdata.
REQ-008 probe  out  PRB_W  JTAG-read response: [PRB_W-1] done toggle, [PRB_W-2:PRB_W-3] status, low DATA_WIDTH bits rdata.
REQ-009 bus_req  out  1  register-bus request, held until ack or timeout.
REQ-010 bus_we  out  1  1 = write, 0 = read; valid while bus_req=1.
REQ-011 bus_addr  out  ADDR_WIDTH  address; valid while bus_req=1.
REQ-012 bus_wdata  out  DATA_WIDTH  write data; valid while bus_req=1.
REQ-013 bus_ack  in  1  one-cycle completion strobe from the register bus.
REQ-014 bus_rdata  in  DATA_WIDTH  read data, valid in the bus_ack cycle.

Function
REQ-015 The whole source bus passes through two synchroniser flops (s1, s2), then one stability flop (s3 = s2 delayed one cycle).
REQ-016 A command is detected in IDLE when s2==s3 (all bits) and s2 toggle != last_tog.
REQ-017 States: IDLE, REQ, DONE; the encoding is left to the implementation.
REQ-018 IDLE -> REQ on detection; the cycle of the transition latches we/addr/wdata/toggle from s2 and clears the wait counter.
REQ-019 REQ: bus_req=1 with the latched fields; the fields are held constant for the entire REQ state.
REQ-020 In REQ, bus_ack=1 captures bus_rdata (read) or the latched wdata (write) and sets status=00; next state DONE.
REQ-021 In REQ without ack, the wait counter increments each cycle; when the counter equals TIMEOUT (TIMEOUT!=0), status=01 and rdata=0; next state DONE.
REQ-022 Ack and timeout in the same cycle: ack wins, status=00.
REQ-023 In DONE, the probe register loads {latched toggle, status, data}, last_tog loads the latched toggle, and the state returns to IDLE.
REQ-024 Probe bits change only in the DONE cycle; done toggle == cmd toggle means the response is ready.
REQ-025 Latency: source toggle edge -> bus_req=1 is 4 clk cycles minimum (2 sync + 1 stability + 1 latch); ack -> probe update is 1 cycle.
REQ-026 Source changes during REQ/DONE are ignored; the command is re-evaluated on return to IDLE because it is compared against last_tog.
REQ-027 Rewriting the same toggle value issues no command, regardless of changes in the other fields.
REQ-028 bus_ack while bus_req=0 is ignored.
REQ-029 Status 10 and 11 are reserved and never driven.
REQ-030 The wait counter is ceil(log2(TIMEOUT+1)) bits and saturates; it never wraps.

Reset
REQ-031 rst=1 immediately forces: state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, probe=0, last_tog=0, s1/s2/s3=0, counter=0.
REQ-032 Reset mid-REQ drops bus_req asynchronously and abandons the command without a probe update.
REQ-033 After release, a source toggle of 1 that is already present issues a command once s2/s3 settle.

Verification
REQ-034 Reset, then source={tog=1,we=1,addr=0x10,wdata=0xDEADBEEF}; ack 2 cycles after req -> bus_req high 4 cycles after the source write, probe={1,00,0xDEADBEEF}.
REQ-035 Read tog=0,addr=0x04; ack with rdata=0x12345678 -> probe={0,00,0x12345678}; bus_we=0 throughout.
REQ-036 TIMEOUT=8, no ack -> bus_req high exactly 9 cycles, probe status=01, rdata=0.
REQ-037 Flip tog and addr while in REQ -> first command completes unchanged; second command issues after DONE->IDLE with the new addr.
REQ-038 Change wdata without toggling, stray ack in IDLE -> no bus_req, probe unchanged.
REQ-039 Assert rst during REQ -> bus_req=0 same cycle, probe=0; after release with tog=1 held -> one command issues.
